c7bicu_brg: RTL and testbench

- Instruction-side bridge that sits directly upstream of the fetch unit (c7bifu).
- Accepts fetch requests on the ic1 request/ack handshake and forwards them to the bus interface unit (BIU) as 8-byte-aligned reads.
- Tracks up to MAX_OUTSTD in-order outstanding reads.
- Registers the returned 64-bit fetch packet onto the ic2 data interface, discarding responses made stale by a fetch cancel.

---
 rtl/c7b_pkg.sv | 24 ++
 rtl/c7bicu_brg_if.sv | 34 +++
 rtl/c7bicu_brg.sv | 78 +++++++
 tb/tb_c7bicu_brg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/c7b_pkg.sv
// Shared definitions for the c7b instruction-side blocks.
package c7b_pkg;

  localparam int unsigned FETCH_W     = 64;
  localparam int unsigned ADDR_W      = 32;
  localparam logic [31:0] RESET_PC    = 32'h1c00_0000;
  localparam int unsigned FETCH_ALIGN = 3;

  // How a BIU return is treated in the cycle it arrives.
  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_LIVE  = 2'd1,
    RESP_STALE = 2'd2
  } resp_e;

  // Clear the low FETCH_ALIGN bits so every BIU read is fetch-packet aligned.
  function automatic logic [ADDR_W-1:0] fetch_align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] a;
    a = addr;
    a[FETCH_ALIGN-1:0] = '0;
    return a;
  endfunction

endpackage

// File: rtl/c7bicu_brg_if.sv
// Fetch-side (ic1/ic2) and BIU-side signals of the instruction bridge.
interface c7bicu_brg_if;
  import c7b_pkg::*;

  logic               ifu_icu_req_ic1;
  logic [ADDR_W-1:0]  ifu_icu_addr_ic1;
  logic               icu_ifu_ack_ic1;
  logic               ifu_icu_cancel;
  logic               icu_ifu_data_valid_ic2;
  logic [FETCH_W-1:0] icu_ifu_data_ic2;
  logic               icu_biu_req;
  logic [ADDR_W-1:0]  icu_biu_addr;
  logic               biu_icu_ack;
  logic               biu_icu_rvalid;
  logic [FETCH_W-1:0] biu_icu_rdata;
  logic               icu_busy;

  // Bridge side.
  modport master (
    input  ifu_icu_req_ic1, ifu_icu_addr_ic1, ifu_icu_cancel,
    input  biu_icu_ack, biu_icu_rvalid, biu_icu_rdata,
    output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
    output icu_biu_req, icu_biu_addr, icu_busy
  );

  // Fetch unit / BIU side.
  modport slave (
    output ifu_icu_req_ic1, ifu_icu_addr_ic1, ifu_icu_cancel,
    output biu_icu_ack, biu_icu_rvalid, biu_icu_rdata,
    input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
    input  icu_biu_req, icu_biu_addr, icu_busy
  );

endinterface

// File: rtl/c7bicu_brg.sv
// Instruction-side bridge: passes fetch requests to the BIU as aligned reads,
// tracks in-order outstanding reads and registers live returns onto ic2,
// discarding returns made stale by a fetch cancel.
module c7bicu_brg
  import c7b_pkg::*;
#(
  parameter int unsigned MAX_OUTSTD = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic           clk,
  input  logic           reset,
  c7bicu_brg_if.master   bus
);

  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               vld_q, vld_d;
  logic [FETCH_W-1:0] data_q, data_d;
  logic               slot_ok;
  logic               accept;
  resp_e              resp;

  // A return in the same cycle frees a slot, so a full bridge can still accept.
  always_comb begin
    slot_ok = (out_cnt_q < CNT_W'(MAX_OUTSTD)) || bus.biu_icu_rvalid;
    accept  = bus.ifu_icu_req_ic1 && slot_ok && bus.biu_icu_ack;
  end

  assign bus.icu_biu_req            = bus.ifu_icu_req_ic1 & slot_ok;
  assign bus.icu_biu_addr           = fetch_align(bus.ifu_icu_addr_ic1);
  assign bus.icu_ifu_ack_ic1        = accept;
  assign bus.icu_ifu_data_valid_ic2 = vld_q & ~bus.ifu_icu_cancel;
  assign bus.icu_ifu_data_ic2       = data_q;
  assign bus.icu_busy               = (out_cnt_q != '0);

  // Classify this cycle's return: stale if a cancel is pending or happening now.
  always_comb begin
    resp = RESP_NONE;
    if (bus.biu_icu_rvalid) begin
      if (bus.ifu_icu_cancel || (drop_cnt_q != '0)) resp = RESP_STALE;
      else                                          resp = RESP_LIVE;
    end
  end

  // Counter and output-register next state.
  always_comb begin
    out_cnt_d  = out_cnt_q + CNT_W'(accept) - CNT_W'(bus.biu_icu_rvalid);
    drop_cnt_d = drop_cnt_q;
    vld_d      = 1'b0;
    data_d     = data_q;
    // A cancel discards everything accepted before this cycle (minus the return
    // consumed now); a request accepted in the cancel cycle is post-flush.
    if (bus.ifu_icu_cancel)
      drop_cnt_d = out_cnt_q - CNT_W'(bus.biu_icu_rvalid);
    else if (resp == RESP_STALE)
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    if (resp == RESP_LIVE) begin
      vld_d  = 1'b1;
      data_d = bus.biu_icu_rdata;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_c7bicu_brg.sv
// Directed bench for c7bicu_brg with a reference model and expected-packet queue.
module tb_c7bicu_brg;

  localparam int unsigned MAX = 2;

  logic clk = 1'b0;
  logic reset;

  c7bicu_brg_if bus();

  c7bicu_brg #(.MAX_OUTSTD(MAX), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference model state
  int unsigned   cnt_m  = 0;
  int unsigned   drop_m = 0;
  logic          vld_m  = 1'b0;
  logic [63:0]   data_m = '0;
  logic [63:0]   exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs currently driven: check combinational
  // outputs, advance the model, then check registered state after the edge.
  task automatic tick(input string tag);
    logic slot, breq, acc, live;
    #1;
    if (vld_m) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_mis++;
        $error("FAIL %s_sb_empty: observed=empty expected=packet", tag);
      end else data_m = exp_q.pop_front();
    end
    slot = (cnt_m < MAX) || bus.biu_icu_rvalid;
    breq = bus.ifu_icu_req_ic1 && slot;
    acc  = breq && bus.biu_icu_ack;
    chk({tag, "_biu_req"}, 64'(bus.icu_biu_req), 64'(breq));
    chk({tag, "_ack"}, 64'(bus.icu_ifu_ack_ic1), 64'(acc));
    chk({tag, "_valid"}, 64'(bus.icu_ifu_data_valid_ic2), 64'(vld_m && !bus.ifu_icu_cancel));
    chk({tag, "_data"}, bus.icu_ifu_data_ic2, data_m);
    if (bus.ifu_icu_req_ic1)
      chk({tag, "_addr"}, 64'(bus.icu_biu_addr), 64'({bus.ifu_icu_addr_ic1[31:3], 3'b000}));
    if (bus.biu_icu_rvalid && cnt_m == 0) begin
      n_cmp++; n_mis++;
      $error("FAIL %s_proto: observed=rvalid expected=no_return_with_zero_outstanding", tag);
    end
    live = bus.biu_icu_rvalid && drop_m == 0 && !bus.ifu_icu_cancel;
    if (bus.ifu_icu_cancel) drop_m = cnt_m - int'(bus.biu_icu_rvalid);
    else if (bus.biu_icu_rvalid && drop_m != 0) drop_m = drop_m - 1;
    cnt_m = cnt_m + int'(acc) - int'(bus.biu_icu_rvalid);
    if (live) exp_q.push_back(bus.biu_icu_rdata);
    vld_m = live;
    @(posedge clk);
    #1;
    chk({tag, "_out_cnt"}, 64'(dut.out_cnt_q), 64'(cnt_m));
    chk({tag, "_drop_cnt"}, 64'(dut.drop_cnt_q), 64'(drop_m));
    chk({tag, "_busy"}, 64'(bus.icu_busy), 64'(cnt_m != 0));
    n_cmp++;
    assert (dut.out_cnt_q <= MAX) else begin
      n_mis++;
      $error("FAIL %s_cnt_bound: observed=%0d expected<=%0d", tag, dut.out_cnt_q, MAX);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic back,
                       input logic rv, input logic [63:0] rd, input logic cxl);
    bus.ifu_icu_req_ic1  = req;
    bus.ifu_icu_addr_ic1 = addr;
    bus.biu_icu_ack      = back;
    bus.biu_icu_rvalid   = rv;
    bus.biu_icu_rdata    = rd;
    bus.ifu_icu_cancel   = cxl;
  endtask

  task automatic model_reset();
    cnt_m = 0; drop_m = 0; vld_m = 1'b0; data_m = '0;
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.icu_ifu_data_valid_ic2), 64'd0);
    chk("rst_data", bus.icu_ifu_data_ic2, 64'd0);
    chk("rst_biu_req", 64'(bus.icu_biu_req), 64'd0);
    chk("rst_busy", 64'(bus.icu_busy), 64'd0);
    reset = 1'b0;

    // Single fetch: request, 3-cycle BIU latency, packet 1 cycle after rvalid
    drive(1'b1, 32'h1c00_0004, 1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("single_addr", 64'(bus.icu_biu_addr), 64'h1c00_0000);
    tick("single_req");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("single_w1");
    tick("single_w2");
    drive(1'b0, '0, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    tick("single_ret");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("single_pkt");
    tick("single_idle");

    // Outstanding limit, then same-cycle return and accept
    drive(1'b1, 32'h1c00_0010, 1'b1, 1'b0, '0, 1'b0);
    tick("lim_a0");
    tick("lim_a1");
    tick("lim_full");
    drive(1'b1, 32'h1c00_0018, 1'b1, 1'b1, 64'h1111_0000_0000_0001, 1'b0);
    tick("lim_swap");
    chk("lim_cnt_hold", 64'(dut.out_cnt_q), 64'd2);
    drive(1'b0, '0, 1'b0, 1'b1, 64'h1111_0000_0000_0002, 1'b0);
    tick("lim_r1");
    drive(1'b0, '0, 1'b0, 1'b1, 64'h1111_0000_0000_0003, 1'b0);
    tick("lim_r2");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("lim_drain");
    tick("lim_idle");

    // Cancel with 2 in flight; D0 returns and a post-flush request is accepted
    drive(1'b1, 32'h1c00_0020, 1'b1, 1'b0, '0, 1'b0);
    tick("cx_a0");
    tick("cx_a1");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("cx_gap");
    drive(1'b1, 32'h1c00_0100, 1'b1, 1'b1, 64'hD0D0_D0D0_D0D0_D0D0, 1'b1);
    tick("cx_cancel");
    drive(1'b0, '0, 1'b0, 1'b1, 64'hD1D1_D1D1_D1D1_D1D1, 1'b0);
    tick("cx_d1");
    drive(1'b0, '0, 1'b0, 1'b1, 64'hD2D2_D2D2_D2D2_D2D2, 1'b0);
    tick("cx_d2");
    chk("cx_drop_zero", 64'(dut.drop_cnt_q), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("cx_pkt");
    tick("cx_idle");

    // Cancel coincides with a would-be-live return; previous packet is masked
    drive(1'b1, 32'h1c00_0200, 1'b1, 1'b0, '0, 1'b0);
    tick("cl_a0");
    tick("cl_a1");
    drive(1'b1, 32'h1c00_0208, 1'b1, 1'b1, 64'hE0E0_0000_0000_0000, 1'b0);
    tick("cl_e0");
    drive(1'b0, '0, 1'b0, 1'b1, 64'hE1E1_0000_0000_0000, 1'b1);
    tick("cl_cancel");
    chk("cl_drop_one", 64'(dut.drop_cnt_q), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 64'hE2E2_0000_0000_0000, 1'b0);
    tick("cl_e2");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("cl_idle");

    // BIU stall, then acceptance when biu_ack rises
    drive(1'b1, 32'h1c00_0300, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) tick("stall");
    drive(1'b1, 32'h1c00_0300, 1'b1, 1'b0, '0, 1'b0);
    tick("stall_go");
    drive(1'b0, '0, 1'b0, 1'b1, 64'h5555_6666_7777_8888, 1'b0);
    tick("stall_ret");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("stall_pkt");

    // Asynchronous reset with 2 in flight
    drive(1'b1, 32'h1c00_0400, 1'b1, 1'b0, '0, 1'b0);
    tick("ar_a0");
    tick("ar_a1");
    #2;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("ar_out_cnt", 64'(dut.out_cnt_q), 64'd0);
    chk("ar_busy", 64'(bus.icu_busy), 64'd0);
    chk("ar_ack", 64'(bus.icu_ifu_ack_ic1), 64'd0);
    chk("ar_biu_req", 64'(bus.icu_biu_req), 64'd0);
    chk("ar_valid", 64'(bus.icu_ifu_data_valid_ic2), 64'd0);
    chk("ar_data", bus.icu_ifu_data_ic2, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 32'h1c00_0004, 1'b1, 1'b0, '0, 1'b0);
    tick("ar2_req");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("ar2_w1");
    tick("ar2_w2");
    drive(1'b0, '0, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    tick("ar2_ret");
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick("ar2_pkt");
    tick("ar2_idle");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
